// File: rtl/cnn_dsp_pkg.sv
// Shared types and helpers for the packed-weight DSP chain tail logic.
// The arithmetic helpers work at a fixed 64-bit width so one function serves
// every field/accumulator width; callers truncate to their own widths.
package cnn_dsp_pkg;

    localparam int DSP_LAT_UNIT = 4;
    localparam int LO_W_DEF     = 18;
    localparam int HI_W_DEF     = 30;
    localparam int P_W          = 48;
    localparam int WIDE_W       = 64;

    // IDLE means the next beat starts a fresh group (base 0).
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } sat_res_t;

    typedef struct packed {
        logic signed [63:0] lo;
        logic signed [63:0] hi;
    } pair_t;

    // Add two operands and clamp the sum into a signed acc_w-bit range.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 acc_w);
        sat_res_t           res;
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        s     = a + b;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (acc_w - 1));
        res.sat   = 1'b0;
        res.value = s;
        if (s > max_v) begin
            res.sat   = 1'b1;
            res.value = max_v;
        end else if (s < min_v) begin
            res.sat   = 1'b1;
            res.value = min_v;
        end
        return res;
    endfunction

    // Split P into its two signed partial sums. A negative low field borrowed
    // one from the high field inside the DSP adder, so add it back.
    function automatic pair_t unpack(input logic [47:0] p, input int lo_w);
        pair_t              res;
        logic signed [63:0] t;
        t      = {p, 16'h0000};
        res.lo = (t <<< (48 - lo_w)) >>> (64 - lo_w);
        res.hi = (t >>> (16 + lo_w)) + (res.lo[63] ? 64'sd1 : 64'sd0);
        return res;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Parametric shift register that carries per-beat control bits alongside
// the DSP pipeline so they line up with the chain-tail P output.
module ctrl_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift one stage per cycle; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/dsp_pair_unpack_acc.sv
// Chain-tail stage: unpacks the two packed partial sums from P, accumulates
// each over a kernel group, and presents saturated results through a
// single-entry valid/ready output register.
module dsp_pair_unpack_acc
    import cnn_dsp_pkg::*;
#(
    parameter int DSP_LAT = DSP_LAT_UNIT,
    parameter int LO_W    = LO_W_DEF,
    parameter int HI_W    = HI_W_DEF,
    parameter int ACC_W   = 32
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic                    I_en,
    input  logic                    I_last,
    input  logic [47:0]             I_p,
    input  logic                    I_ready,
    output logic                    O_valid,
    output logic signed [ACC_W-1:0] O_acc_l,
    output logic signed [ACC_W-1:0] O_acc_h,
    output logic                    O_sat,
    output logic                    O_ovf
);

    logic [1:0]             tap;
    logic                   tap_en;
    logic                   tap_last;
    pair_t                  upk;
    logic                   v1;
    logic                   l1;
    logic signed [LO_W-1:0] lo_q;
    logic signed [HI_W:0]   hi_q;
    acc_state_t             state;
    acc_state_t             state_n;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_h;
    logic                   grp_sat;
    logic signed [63:0]     base_l;
    logic signed [63:0]     base_h;
    sat_res_t               sat_l;
    sat_res_t               sat_h;
    logic                   beat_sat;
    logic                   slot_free;
    logic                   unused_bits;

    ctrl_delay_line #(
        .DEPTH(DSP_LAT),
        .WIDTH(2)
    ) u_ctrl_dly (
        .clk (I_clk),
        .rst (I_rst),
        .din ({I_en, I_en & I_last}),
        .dout(tap)
    );

    assign tap_en   = tap[1];
    assign tap_last = tap[0];

    // Decode the chain-tail word combinationally from the delayed beat.
    always_comb begin
        upk = unpack(I_p, LO_W);
    end

    // Register the unpacked pair and its control bits.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            v1   <= 1'b0;
            l1   <= 1'b0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            v1 <= tap_en;
            l1 <= tap_last;
            if (tap_en) begin
                lo_q <= upk.lo[LO_W-1:0];
                hi_q <= upk.hi[HI_W:0];
            end
        end
    end

    // Group tracking state register.
    always_ff @(posedge I_clk) begin
        if (I_rst) state <= ST_IDLE;
        else       state <= state_n;
    end

    // A last beat always returns to IDLE; any other beat enters ACCUM.
    always_comb begin
        state_n = state;
        if (v1) state_n = l1 ? ST_IDLE : ST_ACCUM;
    end

    // Sum this beat onto the running total (or onto zero for a new group).
    always_comb begin
        base_l    = (state == ST_IDLE) ? 64'sd0 : 64'(acc_l);
        base_h    = (state == ST_IDLE) ? 64'sd0 : 64'(acc_h);
        sat_l     = sat_add(base_l, 64'(lo_q), ACC_W);
        sat_h     = sat_add(base_h, 64'(hi_q), ACC_W);
        beat_sat  = sat_l.sat | sat_h.sat;
        slot_free = !O_valid || I_ready;
    end

    assign unused_bits = ^{upk.lo[63:LO_W], upk.hi[63:HI_W+1],
                           sat_l.value[63:ACC_W], sat_h.value[63:ACC_W]};

    // Accumulators, output slot and sticky overflow.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            acc_l   <= '0;
            acc_h   <= '0;
            grp_sat <= 1'b0;
            O_valid <= 1'b0;
            O_acc_l <= '0;
            O_acc_h <= '0;
            O_sat   <= 1'b0;
            O_ovf   <= 1'b0;
        end else begin
            if (O_valid && I_ready) O_valid <= 1'b0;
            if (v1) begin
                if (!l1) begin
                    acc_l   <= sat_l.value[ACC_W-1:0];
                    acc_h   <= sat_h.value[ACC_W-1:0];
                    grp_sat <= grp_sat | beat_sat;
                end else begin
                    acc_l   <= '0;
                    acc_h   <= '0;
                    grp_sat <= 1'b0;
                    if (slot_free) begin
                        O_acc_l <= sat_l.value[ACC_W-1:0];
                        O_acc_h <= sat_h.value[ACC_W-1:0];
                        O_sat   <= grp_sat | beat_sat;
                        O_valid <= 1'b1;
                    end else begin
                        O_ovf   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/dsp_pair_unpack_acc.md
# dsp_pair_unpack_acc

Downstream stage of the packed-weight DSP multiply chain. Takes the 48-bit P output from the tail DSP of a chain computing `P = {w_h,w_l}*feature + C`. Splits each word into the two signed partial sums (low weight and high weight), corrects the borrow from the low field, and accumulates each over a kernel group delimited by a last flag. Results go out through a single-entry valid/ready register, with saturation and overflow flags.

## Interface
- DSP_LAT, 4: cycles from chain-head feature/weight input to valid P at the chain tail (AREG/BREG 2 + MREG 1 + PREG 1, plus 1 per extra cascaded unit); sets the length of the control delay line.
- LO_W, 18: width of the low packed field in P; the high field starts at bit LO_W.
- HI_W, 30: width of the high field, P[LO_W+HI_W-1:LO_W]; LO_W+HI_W = 48.
- ACC_W, 32: accumulator and output width, signed.
- I_clk  in  1  clock; all logic on the rising edge.
- I_rst  in  1  synchronous reset, active high.
- I_en  in  1  beat valid, aligned with data entering the DSP chain head.
- I_last  in  1  last beat of the current group, aligned with I_en; ignored when I_en=0.
- I_p  in  48  P from the chain-tail DSP, valid DSP_LAT cycles after the matching I_en.
- I_ready  in  1  consumer accepts the output when O_valid & I_ready.
- O_valid  out  1  output result valid; reset 0.
- O_acc_l  out  ACC_W  accumulated low-weight result, signed; reset 0.
- O_acc_h  out  ACC_W  accumulated high-weight result, signed; reset 0.
- O_sat  out  1  result in O_acc_* was clamped; qualified by O_valid; reset 0.
- O_ovf  out  1  sticky: a completed group was dropped; cleared only by I_rst; reset 0.

## Operation
- **Delay line:** {I_en, I_last} are shifted through DSP_LAT registers. The tap pairs with I_p in the same cycle. All stages reset to 0.
- **Unpack stage** (registered, only when the delayed en=1):
  - lo = sign-extend(I_p[LO_W-1:0]).
  - hi = sign-extend(I_p[47:LO_W]) + I_p[LO_W-1], which is the borrow correction.
  - v1 = delayed en; l1 = delayed last.
- **Accumulate stage:** when v1=1:
  - s_l = base_l + lo and s_h = base_h + hi, computed at ACC_W+1 bits.
  - base is 0 when the `first` flag is set; otherwise it is acc.
- **Saturation:** if s exceeds the signed ACC_W range, clamp to max or min. The clamp is recorded in a per-group sat flag.
- **Group continues** (v1 & !l1): acc <= clamped s; first <= 0.
- **Group ends** (v1 & l1):
  - If the output slot is free or being accepted this cycle: O_acc_* <= clamped s; O_sat <= group sat flag OR sat this beat; O_valid <= 1.
  - Otherwise the result is discarded and O_ovf <= 1.
  - In both cases: acc <= 0, first <= 1, sat flag <= 0.
- **Output register:** O_valid drops when O_valid & I_ready and no new result loads in the same cycle. Accept and load in the same cycle gives back-to-back results with O_valid held high.
- **Idle cycles** (v1=0) leave the accumulators untouched; gaps inside a group are allowed.
- **Single-beat group** (I_last on the first beat): the output equals that beat's lo/hi.
- **Reset mid-group** discards the partial sums and the in-flight delay-line contents; first <= 1.

## Timing
- Beat at chain head in cycle t → P at t+DSP_LAT → unpacked at t+DSP_LAT+1 → O_valid high from t+DSP_LAT+2.
- Throughput is one beat per cycle with no input stall. Upstream must not depend on back-pressure; a dropped result sets O_ovf.
- O_acc_*, O_sat are stable while O_valid=1 and I_ready=0.
- The state machine is implicit: ACCUM (first=0) / IDLE (first=1). IDLE→ACCUM on v1&!l1; ACCUM→IDLE on v1&l1; IDLE stays IDLE on v1&l1.

## Structure
- Shared package `cnn_dsp_pkg`: DSP_LAT_UNIT=4, LO_W/HI_W defaults, a sat_add function (ACC_W+1 → ACC_W with flag), and an unpack function.
- One sub-module, `ctrl_delay_line` (parametric depth and width shift register, sync reset). It is reusable for other DSP chain tails.

## Test plan
- **Single beat.** w_h=3, w_l=-2, f=5, so P=(15<<18)-10. Drive I_en=I_last=1 → O_acc_l=-10, O_acc_h=15 (field 14 + borrow 1), O_valid at t+DSP_LAT+2.
- **Four-beat group.**
  - Beats: (lo,hi) = (100,-7), (-50,20), (1,1), (-1,0); last on beat 4 → O_acc_l=50, O_acc_h=14.
  - Same stream with 2 idle cycles inserted between beats 2 and 3 → identical result.
- **Saturation.** ACC_W=16; three beats of lo=+20000 → O_acc_l=32767, O_sat=1. The next group of lo=1 → O_acc_l=1, O_sat=0.
- **Back-pressure and drop.**
  - I_ready=0; two single-beat groups (lo=7, then lo=9) → O_acc_l holds 7 and O_ovf=1.
  - Raise I_ready → the 7 is accepted, O_valid=0, O_ovf stays 1.
- **Back-to-back.** I_ready=1; single-beat groups on consecutive cycles with lo=1,2,3 → O_valid high for 3 consecutive cycles with O_acc_l=1,2,3.
- **Reset mid-group.**
  - Two beats of lo=5, then I_rst for 1 cycle → all outputs 0 and no stale O_valid.
  - Then a single beat lo=4 with last → O_acc_l=4.
